// File: rtl/pcie_tx_symbol_mux.sv
// Transmit-path symbol selector: picks the data byte or one of eight K-code
// symbols by control_dk and registers it, together with a valid flag, for the
// byte-striping stage. Latency is one clock. There is no path from any input
// straight to an output.
module pcie_tx_symbol_mux #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic [DW-1:0] tx_DataE,
  input  logic [DW-1:0] com,
  input  logic [DW-1:0] skp,
  input  logic [DW-1:0] stp,
  input  logic [DW-1:0] sdp,
  input  logic [DW-1:0] end_ok,
  input  logic [DW-1:0] edb,
  input  logic [DW-1:0] fts,
  input  logic [DW-1:0] idle,
  input  logic [CW-1:0] control_dk,
  output logic [DW-1:0] tx_multiplexada,
  output logic          tx_Valid
);

  localparam logic [CW-1:0] CODE_DATA = CW'(0);
  localparam logic [CW-1:0] CODE_COM  = CW'(1);
  localparam logic [CW-1:0] CODE_SKP  = CW'(2);
  localparam logic [CW-1:0] CODE_STP  = CW'(3);
  localparam logic [CW-1:0] CODE_SDP  = CW'(4);
  localparam logic [CW-1:0] CODE_END  = CW'(5);
  localparam logic [CW-1:0] CODE_EDB  = CW'(6);
  localparam logic [CW-1:0] CODE_FTS  = CW'(7);
  localparam logic [CW-1:0] CODE_IDLE = CW'(8);

  logic [DW-1:0] sym_q, sym_d;
  logic          valid_q, valid_d;

  // Select the next symbol. A stall holds the byte but drops valid. Illegal
  // codes, including an unknown (X) code, fall to the default branch, so they
  // send IDLE with valid low.
  always_comb begin
    sym_d   = sym_q;
    valid_d = 1'b0;
    if (enb) begin
      valid_d = 1'b1;
      case (control_dk)
        CODE_DATA: sym_d = tx_DataE;
        CODE_COM:  sym_d = com;
        CODE_SKP:  sym_d = skp;
        CODE_STP:  sym_d = stp;
        CODE_SDP:  sym_d = sdp;
        CODE_END:  sym_d = end_ok;
        CODE_EDB:  sym_d = edb;
        CODE_FTS:  sym_d = fts;
        CODE_IDLE: sym_d = idle;
        default: begin
          sym_d   = idle;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Output registers. Synchronous reset takes priority over enable and code.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sym_q   <= sym_d;
      valid_q <= valid_d;
    end
  end

  assign tx_multiplexada = sym_q;
  assign tx_Valid        = valid_q;

endmodule

// File: tb/tb_pcie_tx_symbol_mux.sv
// Self-checking bench for pcie_tx_symbol_mux: a symbol-table reference model
// checked every cycle, plus directed literal expectations.
module tb_pcie_tx_symbol_mux;

  logic       clk = 1'b0;
  logic       rst, enb;
  logic [7:0] tx_DataE, com, skp, stp, sdp, end_ok, edb, fts, idle;
  logic [3:0] control_dk;
  logic [7:0] tx_multiplexada;
  logic       tx_Valid;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pcie_tx_symbol_mux #(.DW(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .enb(enb), .tx_DataE(tx_DataE),
    .com(com), .skp(skp), .stp(stp), .sdp(sdp), .end_ok(end_ok),
    .edb(edb), .fts(fts), .idle(idle), .control_dk(control_dk),
    .tx_multiplexada(tx_multiplexada), .tx_Valid(tx_Valid)
  );

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: a symbol table indexed by the code; outputs are the
  // previous cycle's decision.
  logic [7:0] syms [0:8];
  always_comb syms = '{tx_DataE, com, skp, stp, sdp, end_ok, edb, fts, idle};

  logic [7:0] m_out;
  logic       m_vld;
  bit         m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_out   <= 8'h00;
      m_vld   <= 1'b0;
      m_known <= 1'b1;
    end else if (!enb) begin
      m_vld <= 1'b0;
    end else if (int'(control_dk) <= 8) begin
      m_out <= syms[int'(control_dk)];
      m_vld <= 1'b1;
    end else begin
      m_out <= idle;
      m_vld <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("model_out", {1'b0, tx_multiplexada}, {1'b0, m_out});
      chk("model_vld", {8'h00, tx_Valid}, {8'h00, m_vld});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] eo, input logic ev);
    chk({nm, "_out"}, {1'b0, tx_multiplexada}, {1'b0, eo});
    chk({nm, "_vld"}, {8'h00, tx_Valid}, {8'h00, ev});
  endtask

  task automatic std_kcodes();
    com = 8'hBC; skp = 8'h1C; stp = 8'hFB; sdp = 8'h5C;
    end_ok = 8'hFD; edb = 8'hFE; fts = 8'h3C; idle = 8'h7C;
  endtask

  logic [7:0] walk_exp [0:8];
  logic [3:0] pkt [$];

  initial begin
    walk_exp = '{8'hFF, 8'hBC, 8'h1C, 8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h3C, 8'h7C};
    std_kcodes();
    rst = 1'b1; enb = 1'b1; control_dk = 4'd0; tx_DataE = 8'h11;

    // Reset for two cycles, then the output follows the code.
    cyc(); lit("rst1", 8'h00, 1'b0);
    cyc(); lit("rst2", 8'h00, 1'b0);
    rst = 1'b0; control_dk = 4'd1;
    cyc(); lit("post_rst", 8'hBC, 1'b1);

    // Walk every legal code.
    tx_DataE = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      control_dk = 4'(i);
      cyc(); lit($sformatf("walk%0d", i), walk_exp[i], 1'b1);
    end

    // Packet sequence, one clock late, valid throughout.
    pkt = {};
    repeat (4) pkt.push_back(4'd8);
    repeat (4) pkt.push_back(4'd1);
    pkt.push_back(4'd3);
    repeat (10) pkt.push_back(4'd0);
    pkt.push_back(4'd5); pkt.push_back(4'd4);
    repeat (2) pkt.push_back(4'd0);
    pkt.push_back(4'd5);
    repeat (4) pkt.push_back(4'd8);
    foreach (pkt[k]) begin
      control_dk = pkt[k];
      tx_DataE   = 8'($urandom);
      cyc();
      chk("pkt_vld", {8'h00, tx_Valid}, 9'h001);
    end

    // Illegal code, then recovery.
    control_dk = 4'd12;
    cyc(); lit("illegal", 8'h7C, 1'b0);
    control_dk = 4'd1;
    cyc(); lit("after_illegal", 8'hBC, 1'b1);

    // Stall holds the byte and drops valid.
    control_dk = 4'd3;
    cyc(); lit("pre_stall", 8'hFB, 1'b1);
    enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      control_dk = 4'($urandom);
      cyc(); lit($sformatf("stall%0d", i), 8'hFB, 1'b0);
    end
    enb = 1'b1; control_dk = 4'd2;
    cyc(); lit("resume", 8'h1C, 1'b1);

    // Mid-stream reset, then data changes tracked with one-cycle latency.
    control_dk = 4'd3;
    cyc(); lit("pre_midrst", 8'hFB, 1'b1);
    rst = 1'b1;
    cyc(); lit("midrst", 8'h00, 1'b0);
    rst = 1'b0; control_dk = 4'd0; tx_DataE = 8'h5A;
    cyc(); lit("data_a", 8'h5A, 1'b1);
    tx_DataE = 8'hA5;
    cyc(); lit("data_b", 8'hA5, 1'b1);

    // Live K-code port values.
    idle = 8'h42; control_dk = 4'd8;
    cyc(); lit("live_idle", 8'h42, 1'b1);
    control_dk = 4'd15;
    cyc(); lit("live_illegal", 8'h42, 1'b0);
    std_kcodes();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      enb        = ($urandom_range(0, 9) != 0);
      control_dk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15))
                                               : 4'($urandom_range(0, 8));
      tx_DataE   = 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        com = 8'($urandom); skp = 8'($urandom); stp = 8'($urandom);
        sdp = 8'($urandom); end_ok = 8'($urandom); edb = 8'($urandom);
        fts = 8'($urandom); idle = 8'($urandom);
      end
      cyc();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
